lif_spike_window_stats: RTL and testbench



---
 rtl/lif_spike_window_stats_if.sv | 32 +++
 rtl/lif_spike_window_stats.sv | 133 +++++++++++++
 tb/tb_lif_spike_window_stats.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lif_spike_window_stats_if.sv
// lif_spike_window_stats_if
// Result readout bundle between the spike-statistics block and its consumer.
//   out_valid   : results are being presented
//   out_ready   : consumer accepts the presented results
//   spike_count : spike rising edges counted in the window (saturating)
//   last_isi    : interval between the last two events, in enabled cycles
//   min_isi     : smallest interval seen in the window
//   isi_valid   : at least two events were seen in the window
//   overflow    : an event arrived while spike_count was already saturated
// master = producer (statistics block), slave = consumer (readout/host).
interface lif_spike_window_stats_if #(
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] spike_count;
  logic [ISI_W-1:0] last_isi;
  logic [ISI_W-1:0] min_isi;
  logic             isi_valid;
  logic             overflow;

  modport master (
    output out_valid, spike_count, last_isi, min_isi, isi_valid, overflow,
    input  out_ready
  );

  modport slave (
    input  out_valid, spike_count, last_isi, min_isi, isi_valid, overflow,
    output out_ready
  );
endinterface

// File: rtl/lif_spike_window_stats.sv
// lif_spike_window_stats
// Counts spike rising edges from the LIF neuron over a window of win_len
// enabled cycles and measures the last and minimum inter-spike intervals.
// Results are presented over a valid/ready handshake and held afterwards
// until the next accepted start.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : global enable; all state frozen while low
//   spike      : spike level from the neuron (rising edge = one event)
//   win_len    : window length in enabled cycles, sampled on accepted start
//   start      : begin a window (only honoured in IDLE with win_len != 0)
//   busy       : high while counting or presenting
//   res        : result bundle (master side)
module lif_spike_window_stats #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8,
  parameter int ISI_W = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ena,
  input  logic                             spike,
  input  logic [WIN_W-1:0]                 win_len,
  input  logic                             start,
  output logic                             busy,
  lif_spike_window_stats_if.master         res
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              spike_d;
  logic [WIN_W-1:0]  remaining;
  logic [ISI_W-1:0]  timer;
  logic              seen;
  logic [CNT_W-1:0]  spike_count;
  logic [ISI_W-1:0]  last_isi;
  logic [ISI_W-1:0]  min_isi;
  logic              isi_valid;
  logic              overflow;

  logic              ev;
  logic              accept_start;
  logic [ISI_W-1:0]  isi;

  assign ev           = spike & ~spike_d;
  assign accept_start = (state == IDLE) && start && (win_len != '0);
  // Interval ending at this event, saturating so a very long gap reads as max.
  assign isi          = (&timer) ? timer : timer + 1'b1;

  // State register; only advances on enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_next;
    end
  end

  // Next-state logic; the window ends on the cycle remaining reaches 1,
  // so the window spans exactly win_len enabled cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_start) state_next = COUNT;
      COUNT:   if (remaining == WIN_W'(1)) state_next = PRESENT;
      PRESENT: if (res.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Measurement datapath. spike_d tracks the level in every state so a level
  // already high when the window opens does not count as an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_d     <= 1'b0;
      remaining   <= '0;
      timer       <= '0;
      seen        <= 1'b0;
      spike_count <= '0;
      last_isi    <= '0;
      min_isi     <= '0;
      isi_valid   <= 1'b0;
      overflow    <= 1'b0;
    end else if (ena) begin
      spike_d <= spike;
      if (accept_start) begin
        remaining   <= win_len;
        timer       <= '0;
        seen        <= 1'b0;
        spike_count <= '0;
        last_isi    <= '0;
        min_isi     <= '1;
        isi_valid   <= 1'b0;
        overflow    <= 1'b0;
      end else if (state == COUNT) begin
        remaining <= remaining - 1'b1;
        if (ev) begin
          if (&spike_count) begin
            overflow <= 1'b1;
          end else begin
            spike_count <= spike_count + 1'b1;
          end
          if (seen) begin
            last_isi  <= isi;
            isi_valid <= 1'b1;
            if (isi < min_isi) begin
              min_isi <= isi;
            end
          end
          seen  <= 1'b1;
          timer <= '0;
        end else if (seen && !(&timer)) begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  assign busy            = (state != IDLE);
  assign res.out_valid   = (state == PRESENT);
  assign res.spike_count = spike_count;
  assign res.last_isi    = last_isi;
  assign res.min_isi     = min_isi;
  assign res.isi_valid   = isi_valid;
  assign res.overflow    = overflow;

endmodule

// File: tb/tb_lif_spike_window_stats.sv
// tb_lif_spike_window_stats
// Directed bench for lif_spike_window_stats. Two instances share stimulus:
// dut (default widths) and dut_small (CNT_W=3) for counter saturation.
// Expected results are pushed to scoreboard queues when a window is driven
// and popped when the design presents out_valid.
module tb_lif_spike_window_stats;

  typedef struct {
    logic [7:0] count;
    logic [7:0] last;
    logic [7:0] min;
    logic       iv;
    logic       ov;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       spike;
  logic [7:0] win_len;
  logic       start;
  logic       busy;
  logic       busy_small;

  int n_assert;
  int n_fail;

  exp_t sb[$];
  exp_t sb_small[$];

  lif_spike_window_stats_if #(.CNT_W(8), .ISI_W(8)) res_if ();
  lif_spike_window_stats_if #(.CNT_W(3), .ISI_W(8)) res_small_if ();

  lif_spike_window_stats #(.CNT_W(8), .WIN_W(8), .ISI_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .spike   (spike),
    .win_len (win_len),
    .start   (start),
    .busy    (busy),
    .res     (res_if)
  );

  lif_spike_window_stats #(.CNT_W(3), .WIN_W(8), .ISI_W(8)) dut_small (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .spike   (spike),
    .win_len (win_len),
    .start   (start),
    .busy    (busy_small),
    .res     (res_small_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one window: level[c] is the spike level in window cycle c.
  task automatic applyStimulus(input int win, input logic [63:0] level, input logic pre_level);
    spike   = pre_level;
    win_len = 8'(win);
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= win; c++) begin
      spike = level[c];
      tick();
    end
    spike = 1'b0;
  endtask

  task automatic cmpResult(input string tag, input exp_t e);
    chk({tag, ".count"}, res_if.spike_count, e.count);
    chk({tag, ".last"},  res_if.last_isi,    e.last);
    chk({tag, ".min"},   res_if.min_isi,     e.min);
    chk({tag, ".iv"},    res_if.isi_valid,   e.iv);
    chk({tag, ".ov"},    res_if.overflow,    e.ov);
  endtask

  // Waits (bounded) for out_valid, then pops and compares the expected result.
  task automatic checkOutput(input string tag, output exp_t e);
    int guard;
    guard = 0;
    while (res_if.out_valid !== 1'b1 && guard < 64) begin
      tick();
      guard++;
    end
    chk({tag, ".out_valid"}, res_if.out_valid, 1'b1);
    chk({tag, ".busy"}, busy, 1'b1);
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("[TB] FAIL %s.scoreboard: observed empty expected entry", tag);
      e = '{8'h0, 8'h0, 8'h0, 1'b0, 1'b0};
    end else begin
      e = sb.pop_front();
      cmpResult(tag, e);
    end
  endtask

  task automatic acceptResult(input string tag, input exp_t e);
    res_if.out_ready       = 1'b1;
    res_small_if.out_ready = 1'b1;
    tick();
    res_if.out_ready       = 1'b0;
    res_small_if.out_ready = 1'b0;
    chk({tag, ".acc_valid"}, res_if.out_valid, 1'b0);
    chk({tag, ".acc_busy"}, busy, 1'b0);
    cmpResult({tag, ".held"}, e);
  endtask

  initial begin
    exp_t e;
    exp_t es;
    logic [63:0] lvl;

    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    ena      = 1'b1;
    spike    = 1'b0;
    win_len  = 8'd0;
    start    = 1'b0;
    res_if.out_ready       = 1'b0;
    res_small_if.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst.busy",  busy, 1'b0);
    chk("rst.valid", res_if.out_valid, 1'b0);
    cmpResult("rst", '{8'd0, 8'd0, 8'd0, 1'b0, 1'b0});
    rst_n = 1'b1;
    tick();

    // Basic window: pulses at cycles 3, 8, 15, then hold with out_ready low
    lvl = '0;
    lvl[3] = 1'b1; lvl[8] = 1'b1; lvl[15] = 1'b1;
    sb.push_back('{8'd3, 8'd7, 8'd5, 1'b1, 1'b0});
    applyStimulus(20, lvl, 1'b0);
    checkOutput("basic", e);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold.valid", res_if.out_valid, 1'b1);
      cmpResult("hold", e);
    end
    acceptResult("basic", e);

    // Level already high at window start: not an event
    lvl = '0;
    for (int c = 1; c <= 10; c++) lvl[c] = 1'b1;
    sb.push_back('{8'd0, 8'd0, 8'd255, 1'b0, 1'b0});
    spike = 1'b1;
    tick();
    applyStimulus(12, lvl, 1'b1);
    checkOutput("prehigh", e);
    acceptResult("prehigh", e);

    // Same level rising in cycle 2: one event
    lvl = '0;
    for (int c = 2; c <= 10; c++) lvl[c] = 1'b1;
    sb.push_back('{8'd1, 8'd0, 8'd255, 1'b0, 1'b0});
    applyStimulus(12, lvl, 1'b0);
    checkOutput("rise2", e);
    acceptResult("rise2", e);

    // Ten pulses every 3 cycles: saturates the 3-bit counter
    lvl = '0;
    for (int k = 0; k < 10; k++) lvl[1 + 3 * k] = 1'b1;
    sb.push_back('{8'd10, 8'd3, 8'd3, 1'b1, 1'b0});
    sb_small.push_back('{8'd7, 8'd3, 8'd3, 1'b1, 1'b1});
    applyStimulus(30, lvl, 1'b0);
    checkOutput("sat", e);
    es = sb_small.pop_front();
    chk("sat_small.valid", res_small_if.out_valid, 1'b1);
    chk("sat_small.count", res_small_if.spike_count, es.count[2:0]);
    chk("sat_small.ov",    res_small_if.overflow, es.ov);
    chk("sat_small.last",  res_small_if.last_isi, es.last);
    chk("sat_small.min",   res_small_if.min_isi, es.min);
    acceptResult("sat", e);

    // Enable gap: 5 frozen clocks with an ignored pulse inside
    sb.push_back('{8'd2, 8'd3, 8'd3, 1'b1, 1'b0});
    win_len = 8'd10;
    start   = 1'b1;
    tick();
    start = 1'b0;
    spike = 1'b0; tick();
    spike = 1'b1; tick();
    spike = 1'b0; tick();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spike = (i == 2);
      tick();
    end
    chk("gap.busy", busy, 1'b1);
    ena = 1'b1;
    spike = 1'b0; tick();
    spike = 1'b1; tick();
    spike = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("gap.valid14", res_if.out_valid, 1'b0);
    tick();
    chk("gap.valid15", res_if.out_valid, 1'b1);
    checkOutput("gap", e);
    acceptResult("gap", e);

    // start with win_len=0 is ignored; previous results stay
    win_len = 8'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("zero.busy", busy, 1'b0);
    chk("zero.valid", res_if.out_valid, 1'b0);
    chk("zero.count", res_if.spike_count, 8'd2);

    // start during COUNT does not restart the window
    sb.push_back('{8'd2, 8'd2, 8'd2, 1'b1, 1'b0});
    win_len = 8'd10;
    start   = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      spike   = (c == 2 || c == 4);
      start   = (c == 5 || c == 6);
      win_len = (c == 5) ? 8'd3 : 8'd10;
      tick();
      if (c == 9) chk("restart.busy9", res_if.out_valid, 1'b0);
    end
    start = 1'b0;
    spike = 1'b0;
    checkOutput("restart", e);
    acceptResult("restart", e);

    // Asynchronous reset mid-COUNT aborts the window
    win_len = 8'd20;
    start   = 1'b1;
    tick();
    start = 1'b0;
    spike = 1'b0; tick();
    spike = 1'b1; tick();
    spike = 1'b0; tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", busy, 1'b0);
    chk("arst.valid", res_if.out_valid, 1'b0);
    cmpResult("arst", '{8'd0, 8'd0, 8'd0, 1'b0, 1'b0});
    #2;
    rst_n = 1'b1;
    tick();
    chk("arst.idle", busy, 1'b0);

    // Clean window after reset
    lvl = '0;
    lvl[1] = 1'b1; lvl[3] = 1'b1;
    sb.push_back('{8'd2, 8'd2, 8'd2, 1'b1, 1'b0});
    applyStimulus(5, lvl, 1'b0);
    checkOutput("post", e);
    acceptResult("post", e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
